window7_gen: RTL
================

Name: window7_gen

Overview:
- Upstream feeder for the 7-input min/med/max sorter in the noise-detection datapath.
- Takes a raster pixel stream, one pixel per handshake, and emits a 7-sample horizontal sliding window centred on each pixel of the row.
- Row edges are handled by clamping (edge replication), so every input pixel produces exactly one window.
- Registered valid/ready handshake on both sides, so the sorter stage can be stalled.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- LINE_WIDTH, 640, pixels per row. Legal range is 4..65535; any other value must fail elaboration via a generate-time check.
- CNT_WIDTH, 16, width of the column counter and of out_col. Must satisfy 2^CNT_WIDTH > LINE_WIDTH.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_pix  input  DATA_WIDTH  input pixel.
- in_valid  input  1  in_pix valid.
- in_ready  output  1  block accepts in_pix this cycle.
- win_1..win_7  output  DATA_WIDTH each  window samples for centre column c: win_k = p[clamp(c-4+k)], where clamp(x) = min(max(x,0), LINE_WIDTH-1). win_1 is leftmost, win_4 is the centre.
- out_col  output  CNT_WIDTH  centre column c of the current window.
- out_sol  output  1  high when c == 0.
- out_eol  output  1  high when c == LINE_WIDTH-1.
- out_valid  output  1  window outputs valid.
- out_ready  input  1  downstream accepts the window.

Behaviour:
- Input transfer: a pixel is transferred when in_valid && in_ready. Output transfer: a window is transferred when out_valid && out_ready.
- Reset, checked every clk edge while rst_n=0, applies fully on the same edge:
  - out_valid=0, win_1..win_7=0, out_col=0, out_sol=0, out_eol=0.
  - State=FILL, column counter=0, shift register cleared.
  - Reset mid-row discards the partial row and any pending window. The first pixel accepted after reset is column 0.
- Internal storage: a 7-entry shift register of pixels plus a column counter col_in (index of the next pixel to accept). Output registers are separate from the shift register.
- State FILL (col_in in 0..2):
  - in_ready=1. Accepted pixels are stored only; no window is produced.
  - On accepting p0, the left-edge entries are preloaded with p0 (left clamp).
  - Accepting p2 moves to RUN.
- State RUN (col_in in 3..LINE_WIDTH-1):
  - in_ready = !out_valid || out_ready.
  - Accepting p[j] loads the window for c=j-3 into the output registers on the same edge, and sets out_valid=1 on the next cycle.
  - Latency from acceptance of p[c+3] to out_valid: 1 cycle.
  - Accepting p[LINE_WIDTH-1] moves to FLUSH.
- State FLUSH:
  - in_ready=0.
  - Emits windows for c = LINE_WIDTH-3, LINE_WIDTH-2, LINE_WIDTH-1, using p[LINE_WIDTH-1] for every position beyond the row end (right clamp).
  - Each flush window is loaded when !out_valid || out_ready, so flush windows go out back-to-back under out_ready=1.
  - After loading c=LINE_WIDTH-1: col_in=0, state returns to FILL.
- Overlap: FILL of the next row may accept pixels while the last window of the previous row is still held, because the shift register and output registers are independent.
- Output stability: while out_valid && !out_ready, all outputs hold their values.
- Throughput: one window per cycle in steady state. Per row, exactly LINE_WIDTH windows, in column order, are produced for LINE_WIDTH pixels accepted.
- out_sol/out_eol are derived from the centre column being loaded, never from the input side.
- in_valid without in_ready is a no-op. in_pix is ignored when not transferred.
- No arithmetic on pixel data. The column counter wraps only at LINE_WIDTH, never at 2^CNT_WIDTH.

Test Plan:
- Basic row (LINE_WIDTH=8, pixels 10,20,...,80, in_valid=1, out_ready=1):
  - 8 windows in order.
  - c=0 is {10,10,10,10,20,30,40} with out_sol=1.
  - c=3 is {10,20,30,40,50,60,70}.
  - c=7 is {50,60,70,80,80,80,80} with out_eol=1.
  - First out_valid appears 1 cycle after p3 is accepted.
- Minimum row (LINE_WIDTH=4, pixels 1,2,3,4):
  - c=0 is {1,1,1,1,2,3,4}.
  - c=3 is {1,2,3,4,4,4,4}.
  - Exactly 3 flush windows, with in_ready=0 throughout FLUSH.
- Backpressure (LINE_WIDTH=8, out_ready low for 5 cycles at c=2):
  - Window {10,10,20,30,40,50,60} holds stable.
  - in_ready=0 in RUN during the stall.
  - No pixel is lost or duplicated, and all 8 windows arrive in order.
- Back-to-back rows (two rows of 8, second row 100..170, in_valid held high):
  - Second row's FILL overlaps the first row's flush.
  - Second row's c=0 is {100,100,100,100,110,120,130} with no leftover first-row data.
- Reset mid-row (assert rst_n=0 for 1 cycle after p5 of a row):
  - Next cycle: out_valid=0 and all outputs 0.
  - A fresh row then produces c=0 built only from post-reset pixels.
- Bubbles (in_valid random 50%, out_ready random 70%, 3 rows of LINE_WIDTH=16):
  - Scoreboard against the clamp formula; 48 windows exact.

Source files
------------

// File: rtl/window7_gen.sv
// window7_gen: 7-tap horizontal sliding window generator with edge-clamped row borders
// Ports: clk, rst_n (sync, active-low); in_pix/in_valid/in_ready pixel stream in;
//        win_1..win_7 (win_4 = centre), out_col, out_sol, out_eol, out_valid/out_ready window stream out.
module window7_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WIDTH = 640,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_pix,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] win_1,
  output logic [DATA_WIDTH-1:0] win_2,
  output logic [DATA_WIDTH-1:0] win_3,
  output logic [DATA_WIDTH-1:0] win_4,
  output logic [DATA_WIDTH-1:0] win_5,
  output logic [DATA_WIDTH-1:0] win_6,
  output logic [DATA_WIDTH-1:0] win_7,
  output logic [CNT_WIDTH-1:0]  out_col,
  output logic                  out_sol,
  output logic                  out_eol,
  output logic                  out_valid,
  input  logic                  out_ready
);
  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
  if (LINE_WIDTH < 4 || LINE_WIDTH > 65535 || (64'd1 << CNT_WIDTH) <= 64'(LINE_WIDTH)) begin : g_bad_param
    $error("window7_gen: illegal LINE_WIDTH/CNT_WIDTH combination");
  end
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] col_in_q, col_in_d, out_col_q, out_col_d, load_col;
  logic [1:0] fl_q, fl_d;
  logic [DATA_WIDTH-1:0] sr_q [7], sr_d [7], sh [7], win_q [7], win_d [7];
  logic out_valid_q, out_valid_d, out_sol_q, out_sol_d, out_eol_q, out_eol_d;
  logic load_ok, acc, load, fill_acc;
  always_comb begin
    load_ok = !out_valid_q || out_ready;
    in_ready = state_q == FILL || (state_q == RUN && load_ok);
    acc = in_valid && in_ready;
    fill_acc = state_q == FILL && acc;
    load = state_q == FLUSH ? load_ok : state_q == RUN && acc;
    // flush columns are counted separately so col_in never has to exceed LINE_WIDTH-1
    load_col = state_q == FLUSH ? CNT_WIDTH'(LINE_WIDTH - 3) + CNT_WIDTH'(fl_q) : col_in_q - CNT_WIDTH'(3);
    for (int i = 0; i < 6; i++) sh[i] = sr_q[i + 1];
    // past the row end the newest pixel is replicated (right clamp)
    sh[6] = state_q == FLUSH ? sr_q[6] : in_pix;
    for (int i = 0; i < 7; i++) begin
      // column 0 floods every tap so the left taps read p0 (left clamp)
      sr_d[i] = fill_acc && col_in_q == '0 ? in_pix : fill_acc || load ? sh[i] : sr_q[i];
      win_d[i] = load ? sh[i] : win_q[i];
    end
    out_valid_d = load || (out_valid_q && !out_ready);
    out_col_d = load ? load_col : out_col_q;
    out_sol_d = load ? load_col == '0 : out_sol_q;
    out_eol_d = load ? load_col == CNT_WIDTH'(LINE_WIDTH - 1) : out_eol_q;
    col_in_d = acc ? (col_in_q == CNT_WIDTH'(LINE_WIDTH - 1) ? '0 : col_in_q + CNT_WIDTH'(1)) : col_in_q;
    fl_d = state_q == FLUSH && load_ok ? (fl_q == 2'd2 ? 2'd0 : fl_q + 2'd1) : fl_q;
    state_d = fill_acc && col_in_q == CNT_WIDTH'(2) ? RUN
            : state_q == RUN && acc && col_in_q == CNT_WIDTH'(LINE_WIDTH - 1) ? FLUSH
            : state_q == FLUSH && load_ok && fl_q == 2'd2 ? FILL : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      col_in_q <= '0;
      fl_q <= '0;
      sr_q <= '{default: '0};
      win_q <= '{default: '0};
      out_valid_q <= 1'b0;
      out_col_q <= '0;
      out_sol_q <= 1'b0;
      out_eol_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_in_q <= col_in_d;
      fl_q <= fl_d;
      sr_q <= sr_d;
      win_q <= win_d;
      out_valid_q <= out_valid_d;
      out_col_q <= out_col_d;
      out_sol_q <= out_sol_d;
      out_eol_q <= out_eol_d;
    end
  end
  assign win_1 = win_q[0];
  assign win_2 = win_q[1];
  assign win_3 = win_q[2];
  assign win_4 = win_q[3];
  assign win_5 = win_q[4];
  assign win_6 = win_q[5];
  assign win_7 = win_q[6];
  assign out_col = out_col_q;
  assign out_sol = out_sol_q;
  assign out_eol = out_eol_q;
  assign out_valid = out_valid_q;
endmodule
